mcp_control: RTL and testbench

MCP_CONTROL -- requirements
Module: mcp_control

---
 rtl/mcp_control.sv | 196 +++++++++++++++++++
 tb/tb_mcp_control.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mcp_control.sv
// Multicycle MIPS-style control FSM: Moore decode of the registered state, with FETCH strobes gated by mem_ready.
// Optional feature: define MCP_BNE_EN to decode bne (0x05) into BRANCH with branch_ne asserted.
module mcp_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       branch_ne,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MCP_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  state_t cur;
  logic   is_sw;   // load/store direction captured in DECODE, used by MEMADR
  logic   ill_q;
`ifdef MCP_BNE_EN
  logic   bne_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur   <= FETCH;
      is_sw <= 1'b0;
      ill_q <= 1'b0;
`ifdef MCP_BNE_EN
      bne_q <= 1'b0;
`endif
    end else begin
      ill_q <= 1'b0;
      case (cur)
        FETCH: begin
          if (mem_ready) cur <= DECODE;
        end
        DECODE: begin
`ifdef MCP_BNE_EN
          bne_q <= 1'b0;
`endif
          case (opcode)
            OP_LW: begin
              cur   <= MEMADR;
              is_sw <= 1'b0;
            end
            OP_SW: begin
              cur   <= MEMADR;
              is_sw <= 1'b1;
            end
            OP_RTYPE: cur <= EXEC;
            OP_BEQ:   cur <= BRANCH;
            OP_ADDI:  cur <= ADDIEX;
            OP_J:     cur <= JUMP;
`ifdef MCP_BNE_EN
            OP_BNE: begin
              cur   <= BRANCH;
              bne_q <= 1'b1;
            end
`endif
            default: begin
              cur   <= FETCH;
              ill_q <= 1'b1;
            end
          endcase
        end
        MEMADR: cur <= is_sw ? MEMWR : MEMRD;
        MEMRD: begin
          if (mem_ready) cur <= MEMWB;
        end
        MEMWB: cur <= FETCH;
        MEMWR: begin
          if (mem_ready) cur <= FETCH;
        end
        EXEC:   cur <= ALUWB;
        ALUWB:  cur <= FETCH;
        BRANCH: cur <= FETCH;
        ADDIEX: cur <= ADDIWB;
        ADDIWB: cur <= FETCH;
        JUMP:   cur <= FETCH;
        default: cur <= FETCH;
      endcase
    end
  end

  // Outputs decode from state; rst_n blanks everything so no strobe fires while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    branch_ne     = 1'b0;
    illegal       = 1'b0;
    state         = 4'd0;
    if (rst_n) begin
      state   = cur;
      illegal = ill_q;
      case (cur)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = 2'b11;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
`ifdef MCP_BNE_EN
          branch_ne     = bne_q;
`endif
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDIWB: reg_write = 1'b1;
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_control.sv
// Table-driven bench for mcp_control: per-cycle {rst_n, opcode, mem_ready} rows with hand-computed expected outputs.
module tb_mcp_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       branch_ne, illegal;
  logic [3:0] state;

  mcp_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .branch_ne(branch_ne), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,
  //  alu_src_b,alu_op,pc_source,branch_ne,illegal,state}
  localparam logic [21:0] F_R  = {10'b1001010000, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0};
  localparam logic [21:0] F_W  = {10'b0001000000, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0};
  localparam logic [21:0] DEC  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 2'b00, 4'd1};
  localparam logic [21:0] MADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00, 4'd2};
  localparam logic [21:0] MRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd3};
  localparam logic [21:0] MWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd4};
  localparam logic [21:0] MWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd5};
  localparam logic [21:0] EXE  = {10'b0000000001, 2'b00, 2'b10, 2'b00, 2'b00, 4'd6};
  localparam logic [21:0] AWB  = {10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7};
  localparam logic [21:0] BR   = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b00, 4'd8};
  localparam logic [21:0] AIEX = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00, 4'd9};
  localparam logic [21:0] AIWB = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd10};
  localparam logic [21:0] JMP  = {10'b1000000000, 2'b00, 2'b00, 2'b10, 2'b00, 4'd11};
  localparam logic [21:0] RST  = 22'h0;
  localparam logic [21:0] ILL  = 22'h10;
`ifdef MCP_BNE_EN
  localparam logic [21:0] BNE  = 22'h20;
`endif

  typedef struct {
    string       name;
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   nv;
  int   checks;
  int   errors;

  function automatic logic [21:0] outs();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a,
            alu_src_b, alu_op, pc_source, branch_ne, illegal, state};
  endfunction

  function automatic void add(string name, logic r, logic [5:0] op, logic mr, logic [21:0] exp);
    vecs[nv].name  = name;
    vecs[nv].rst_n = r;
    vecs[nv].op    = op;
    vecs[nv].mr    = mr;
    vecs[nv].exp   = exp;
    nv++;
  endfunction

  task automatic chk(input string name, input logic [21:0] got, input logic [21:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic mr);
    @(negedge clk);
    rst_n     = r;
    opcode    = op;
    mem_ready = mr;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    nv = 0; checks = 0; errors = 0;

    add("rst0",     1'b0, 6'h00, 1'b0, RST);
    add("rst1",     1'b0, 6'h00, 1'b1, RST);
    add("lw_f",     1'b1, 6'h23, 1'b1, F_R);
    add("lw_d",     1'b1, 6'h23, 1'b1, DEC);
    add("lw_ma",    1'b1, 6'h23, 1'b1, MADR);
    add("lw_rd",    1'b1, 6'h23, 1'b1, MRD);
    add("lw_wb",    1'b1, 6'h23, 1'b1, MWB);
    add("beq_f",    1'b1, 6'h04, 1'b1, F_R);
    add("beq_d",    1'b1, 6'h04, 1'b1, DEC);
    add("beq_br",   1'b1, 6'h04, 1'b1, BR);
    add("j_f",      1'b1, 6'h02, 1'b1, F_R);
    add("j_d",      1'b1, 6'h02, 1'b1, DEC);
    add("j_j",      1'b1, 6'h02, 1'b1, JMP);
    add("r_f",      1'b1, 6'h00, 1'b1, F_R);
    add("r_d",      1'b1, 6'h00, 1'b1, DEC);
    add("r_ex",     1'b1, 6'h00, 1'b1, EXE);
    add("r_wb",     1'b1, 6'h00, 1'b1, AWB);
    add("addi_f",   1'b1, 6'h08, 1'b1, F_R);
    add("addi_d",   1'b1, 6'h08, 1'b1, DEC);
    add("addi_ex",  1'b1, 6'h08, 1'b1, AIEX);
    add("addi_wb",  1'b1, 6'h08, 1'b1, AIWB);
    add("ill_f",    1'b1, 6'h3F, 1'b1, F_R);
    add("ill_d",    1'b1, 6'h3F, 1'b1, DEC);
    add("ill_pls",  1'b1, 6'h00, 1'b0, F_W | ILL);
    add("fwait2",   1'b1, 6'h00, 1'b0, F_W);
    add("bne_f",    1'b1, 6'h05, 1'b1, F_R);
    add("bne_d",    1'b1, 6'h05, 1'b1, DEC);
`ifdef MCP_BNE_EN
    add("bne_br",   1'b1, 6'h05, 1'b1, BR | BNE);
    add("sw_f",     1'b1, 6'h2B, 1'b1, F_R);
`else
    add("bne_ill",  1'b1, 6'h2B, 1'b1, F_R | ILL);
`endif
    add("sw_d",     1'b1, 6'h2B, 1'b1, DEC);
    add("sw_ma",    1'b1, 6'h2B, 1'b1, MADR);
    add("sw_w0",    1'b1, 6'h2B, 1'b0, MWR);
    add("sw_w1",    1'b1, 6'h2B, 1'b0, MWR);
    add("sw_w2",    1'b1, 6'h2B, 1'b0, MWR);
    add("sw_w3",    1'b1, 6'h2B, 1'b1, MWR);
    add("lw2_f",    1'b1, 6'h23, 1'b1, F_R);
    add("lw2_d",    1'b1, 6'h23, 1'b1, DEC);
    add("lw2_ma",   1'b1, 6'h23, 1'b1, MADR);
    add("lw2_rd0",  1'b1, 6'h23, 1'b0, MRD);
    add("lw2_rd1",  1'b1, 6'h23, 1'b0, MRD);
    add("rst_rd",   1'b0, 6'h23, 1'b1, RST);
    add("rst_f",    1'b0, 6'h23, 1'b1, RST);
    add("post_w",   1'b1, 6'h00, 1'b0, F_W);
    add("post_r",   1'b1, 6'h00, 1'b1, F_R);
    add("rst_end",  1'b0, 6'h00, 1'b0, RST);

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].rst_n, vecs[i].op, vecs[i].mr);
      chk(vecs[i].name, outs(), vecs[i].exp);
    end

    // lw with a long memory stall: MEMRD must hold until mem_ready.
    step(1'b1, 6'h23, 1'b1); chk("hs_f",  outs(), F_R);
    step(1'b1, 6'h23, 1'b1); chk("hs_d",  outs(), DEC);
    step(1'b1, 6'h23, 1'b1); chk("hs_ma", outs(), MADR);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 6'h23, 1'b0);
      chk("hs_hold", outs(), MRD);
    end
    step(1'b1, 6'h23, 1'b1); chk("hs_rdy", outs(), MRD);
    step(1'b1, 6'h23, 1'b1); chk("hs_wb",  outs(), MWB);
    step(1'b1, 6'h00, 1'b0); chk("hs_fw",  outs(), F_W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
